// File: rtl/npu_common_pkg.sv
// Shared helpers for the NPU FIFO family.
// Pointer arithmetic for storage depths that need not be a power of two.
package npu_common_pkg;

    // ptr + n is always below 2*depth, so one subtract is enough to wrap.
    function automatic int unsigned ptr_wrap_add(
        input int unsigned ptr,
        input int unsigned n,
        input int unsigned depth
    );
        int unsigned s;
        s = ptr + n;
        if (s >= depth)
            s = s - depth;
        return s;
    endfunction

endpackage

// File: rtl/fifo_multi_lane_no_rst_data.sv
// Multi-lane FIFO: up to WR_LANES pushes and RD_LANES pops per cycle.
// Storage is not reset; pointers, occupancy and flags are.
module fifo_multi_lane_no_rst_data
    import npu_common_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int WR_LANES  = 4,
    parameter int RD_LANES  = 2,
    parameter int AF_THRESH = DEPTH - WR_LANES,
    localparam int DEPTH_BIT = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCP_BIT   = $clog2(DEPTH + 1),
    localparam int WN_BIT    = $clog2(WR_LANES + 1),
    localparam int RN_BIT    = $clog2(RD_LANES + 1)
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_flush,
    output logic                               o_input_ready,
    input  logic                               i_input_valid,
    input  logic [WN_BIT-1:0]                  i_input_num,
    input  logic [WR_LANES-1:0][WIDTH-1:0]     i_input_data,
    input  logic                               i_output_ready,
    output logic                               o_output_valid,
    output logic [RN_BIT-1:0]                  o_output_num,
    output logic [RD_LANES-1:0][WIDTH-1:0]     o_output_data,
    output logic [OCP_BIT-1:0]                 o_occupy,
    output logic                               o_almost_full
);

    localparam logic [OCP_BIT-1:0] FREE_LIM = OCP_BIT'(DEPTH - WR_LANES);
    localparam logic [OCP_BIT-1:0] AF_LIM   = OCP_BIT'(AF_THRESH);
    localparam logic [OCP_BIT-1:0] RD_OCP   = OCP_BIT'(RD_LANES);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_BIT-1:0] wr_ptr;
    logic [DEPTH_BIT-1:0] rd_ptr;
    logic [OCP_BIT-1:0]   occupy;

    logic                 wr_en;
    logic                 rd_en;
    logic [WN_BIT-1:0]    push_n;
    logic [RN_BIT-1:0]    pop_n;
    logic [OCP_BIT:0]     occ_sum;
    logic [DEPTH_BIT-1:0] wr_ptr_nxt;
    logic [DEPTH_BIT-1:0] rd_ptr_nxt;
    logic [DEPTH_BIT-1:0] wr_idx [WR_LANES];
    logic [DEPTH_BIT-1:0] rd_idx [RD_LANES];

    // Ready looks only at state so there is no path from i_input_num.
    assign o_input_ready  = (occupy <= FREE_LIM);
    assign o_output_valid = (occupy != '0);
    assign o_output_num   = (occupy >= RD_OCP) ? RN_BIT'(RD_LANES)
                                               : RN_BIT'(occupy);
    assign o_occupy       = occupy;
    assign o_almost_full  = (occupy >= AF_LIM);

    assign wr_en  = i_input_valid & o_input_ready;
    assign rd_en  = i_output_ready & o_output_valid;
    assign push_n = wr_en ? i_input_num : '0;
    assign pop_n  = rd_en ? o_output_num : '0;

    assign occ_sum = {1'b0, occupy}
                   + (OCP_BIT + 1)'(push_n)
                   - (OCP_BIT + 1)'(pop_n);

    assign wr_ptr_nxt = DEPTH_BIT'(ptr_wrap_add(32'(wr_ptr), 32'(push_n), DEPTH));
    assign rd_ptr_nxt = DEPTH_BIT'(ptr_wrap_add(32'(rd_ptr), 32'(pop_n), DEPTH));

    for (genvar g = 0; g < WR_LANES; g++) begin : g_wr_lane
        assign wr_idx[g] = DEPTH_BIT'(ptr_wrap_add(32'(wr_ptr), g, DEPTH));
    end

    for (genvar g = 0; g < RD_LANES; g++) begin : g_rd_lane
        assign rd_idx[g]        = DEPTH_BIT'(ptr_wrap_add(32'(rd_ptr), g, DEPTH));
        assign o_output_data[g] = mem[rd_idx[g]];
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < WR_LANES; k++) begin
            if (wr_en && !i_flush && (WN_BIT'(k) < i_input_num))
                mem[wr_idx[k]] <= i_input_data[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occupy <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occupy <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            occupy <= OCP_BIT'(occ_sum);
        end
    end

endmodule

// File: tb/tb_fifo_multi_lane_no_rst_data.sv
// Scoreboard bench for fifo_multi_lane_no_rst_data.
// Directed pushes feed a queue; a negedge monitor pops and compares.
module tb_fifo_multi_lane_no_rst_data;

    typedef logic [2:0][7:0] wr_t;

    logic            i_clk;
    logic            i_reset;
    logic            i_flush;
    logic            o_input_ready;
    logic            i_input_valid;
    logic [1:0]      i_input_num;
    wr_t             i_input_data;
    logic            i_output_ready;
    logic            o_output_valid;
    logic [1:0]      o_output_num;
    logic [1:0][7:0] o_output_data;
    logic [2:0]      o_occupy;
    logic            o_almost_full;

    logic [7:0] q[$];
    int vectors;
    int miscompares;

    fifo_multi_lane_no_rst_data #(
        .WIDTH(8), .DEPTH(6), .WR_LANES(3), .RD_LANES(2), .AF_THRESH(4)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_flush(i_flush),
        .o_input_ready(o_input_ready),
        .i_input_valid(i_input_valid),
        .i_input_num(i_input_num),
        .i_input_data(i_input_data),
        .i_output_ready(i_output_ready),
        .o_output_valid(o_output_valid),
        .o_output_num(o_output_num),
        .o_output_data(o_output_data),
        .o_occupy(o_occupy),
        .o_almost_full(o_almost_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (i_reset && i_input_valid)
            assert (i_input_num <= 2'd3)
            else $error("illegal i_input_num %0d", i_input_num);
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic wr_t lanes(input logic [7:0] a, b, c);
        return {c, b, a};
    endfunction

    // Drive one cycle of stimulus; record accepted data after the edge.
    task automatic cyc(input logic v, input int n, input wr_t d,
                       input logic rdy, input logic fl, input logic acc);
        i_input_valid  = v;
        i_input_num    = 2'(n);
        i_input_data   = d;
        i_output_ready = rdy;
        i_flush        = fl;
        @(posedge i_clk);
        #1;
        if (fl)
            q.delete();
        else if (acc)
            for (int k = 0; k < n; k++) q.push_back(d[k]);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 0, '0, rdy, 1'b0, 1'b0);
    endtask

    always @(negedge i_clk) begin : mon
        int sz;
        int n;
        if (i_reset) begin
            sz = q.size();
            n  = (sz >= 2) ? 2 : sz;
            chk("occupy", int'(o_occupy), sz);
            chk("valid", int'(o_output_valid), int'(sz != 0));
            chk("num", int'(o_output_num), n);
            chk("in_ready", int'(o_input_ready), int'(sz <= 3));
            chk("almost_full", int'(o_almost_full), int'(sz >= 4));
            if (i_output_ready && !i_flush) begin
                for (int k = 0; k < n; k++)
                    chk($sformatf("data_lane%0d", k),
                        int'(o_output_data[k]), int'(q.pop_front()));
            end
        end
    end

    initial begin
        vectors        = 0;
        miscompares    = 0;
        i_reset        = 1'b0;
        i_flush        = 1'b0;
        i_input_valid  = 1'b0;
        i_input_num    = '0;
        i_input_data   = '0;
        i_output_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b1;
        chk("rst_ready", int'(o_input_ready), 1);
        chk("rst_valid", int'(o_output_valid), 0);
        chk("rst_num", int'(o_output_num), 0);
        chk("rst_occupy", int'(o_occupy), 0);
        chk("rst_af", int'(o_almost_full), 0);

        // fill to full, then drain
        cyc(1, 3, lanes(8'hA0, 8'hA1, 8'hA2), 0, 0, 1);
        cyc(1, 3, lanes(8'hB0, 8'hB1, 8'hB2), 0, 0, 1);
        chk("full_occupy", int'(o_occupy), 6);
        chk("full_ready", int'(o_input_ready), 0);
        chk("full_af", int'(o_almost_full), 1);
        repeat (3) idle(1);
        idle(0);
        chk("drained_valid", int'(o_output_valid), 0);

        // move pointers to 5, then wrap
        cyc(1, 3, lanes(8'hD0, 8'hD1, 8'hD2), 0, 0, 1);
        cyc(1, 2, lanes(8'hD3, 8'hD4, 8'h00), 0, 0, 1);
        repeat (3) idle(1);
        cyc(1, 2, lanes(8'hC0, 8'hC1, 8'h00), 0, 0, 1);
        chk("wrap_num", int'(o_output_num), 2);
        idle(1);
        cyc(1, 1, lanes(8'hE0, 8'h00, 8'h00), 0, 0, 1);
        chk("partial_num", int'(o_output_num), 1);
        idle(1);

        // simultaneous push and pop
        cyc(1, 3, lanes(8'hF0, 8'hF1, 8'hF2), 0, 0, 1);
        cyc(1, 3, lanes(8'h10, 8'h11, 8'h12), 1, 0, 1);
        chk("simul_occupy", int'(o_occupy), 4);
        idle(1);
        cyc(1, 3, lanes(8'h20, 8'h21, 8'h22), 0, 0, 1);
        idle(1);
        cyc(1, 3, lanes(8'h30, 8'h31, 8'h32), 0, 0, 1);
        chk("simul_full", int'(o_occupy), 6);
        cyc(1, 3, lanes(8'h40, 8'h41, 8'h42), 1, 0, 0);
        chk("pop_at_full", int'(o_occupy), 4);
        repeat (2) idle(1);

        // flush overrides push
        cyc(1, 3, lanes(8'h50, 8'h51, 8'h52), 0, 0, 1);
        cyc(1, 2, lanes(8'h53, 8'h54, 8'h00), 0, 0, 1);
        chk("pre_flush", int'(o_occupy), 5);
        cyc(1, 3, lanes(8'h60, 8'h61, 8'h62), 0, 1, 0);
        chk("flush_occupy", int'(o_occupy), 0);
        chk("flush_valid", int'(o_output_valid), 0);
        cyc(1, 3, lanes(8'h70, 8'h71, 8'h72), 0, 1, 1);
        chk("flush_push_occupy", int'(o_occupy), 0);
        cyc(1, 1, lanes(8'h80, 8'h00, 8'h00), 0, 0, 1);
        idle(1);

        // async reset between edges
        cyc(1, 3, lanes(8'h90, 8'h91, 8'h92), 0, 0, 1);
        cyc(1, 1, lanes(8'h93, 8'h00, 8'h00), 0, 0, 1);
        chk("pre_areset", int'(o_occupy), 4);
        i_input_valid = 1'b0;
        #2 i_reset = 1'b0;
        q.delete();
        #1;
        chk("areset_occupy", int'(o_occupy), 0);
        chk("areset_valid", int'(o_output_valid), 0);
        chk("areset_ready", int'(o_input_ready), 1);
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        cyc(1, 2, lanes(8'hE1, 8'hE2, 8'h00), 0, 0, 1);
        idle(1);
        idle(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
